// File: rtl/adc_moving_avg.sv
// Moving-average filter over the last 2**LOG2N ADC samples, stepped by a small FSM.
// Unwritten window slots read as zero, so the average ramps up from reset or flush.
module adc_moving_avg #(
  parameter int LOG2N = 4
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  input  logic       flush,
  output logic [9:0] avg_out,
  output logic       avg_valid,
  output logic       full,
  output logic       busy,
  output logic       overrun
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = 10 + LOG2N;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_UPDATE = 3'd2,
    S_OUTPUT = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_dv_d;
  logic               r_armed;
  logic [9:0]         r_buf [N];
  logic [LOG2N-1:0]   r_wr_ptr;
  logic [SW-1:0]      r_sum;
  logic [LOG2N:0]     r_fill;
  logic [9:0]         r_sample;
  logic [9:0]         r_oldest;
  logic [9:0]         r_avg_out;
  logic               r_avg_valid;
  logic               r_full;
  logic               r_busy;
  logic               r_overrun;

  logic               w_edge;
  logic [SW-1:0]      w_sum_next;
  logic [LOG2N:0]     w_fill_next;

  // r_armed blocks a data_valid that was already high when reset released
  assign w_edge      = data_valid & ~r_dv_d & r_armed;
  assign w_sum_next  = r_sum + SW'(r_sample) - SW'(r_oldest);
  assign w_fill_next = (r_fill == (LOG2N+1)'(N)) ? r_fill : r_fill + (LOG2N+1)'(1);

  // Sample-edge detection, window bookkeeping and sequencing FSM
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dv_d      <= 1'b0;
      r_armed     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= 10'd0;
      end
      r_wr_ptr    <= {LOG2N{1'b0}};
      r_sum       <= {SW{1'b0}};
      r_fill      <= {(LOG2N+1){1'b0}};
      r_sample    <= 10'd0;
      r_oldest    <= 10'd0;
      r_avg_out   <= 10'd0;
      r_avg_valid <= 1'b0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_dv_d  <= data_valid;
      r_armed <= r_armed | ~data_valid;

      if (w_edge && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_avg_valid <= 1'b0;
          if (flush) begin
            r_wr_ptr <= {LOG2N{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= S_CLEAR;
          end else if (w_edge) begin
            r_sample <= data_in;
            r_busy   <= 1'b1;
            r_state  <= S_READ;
          end else begin
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_READ: begin
          r_oldest <= r_buf[r_wr_ptr];
          r_state  <= S_UPDATE;
        end
        // avg_out is loaded from the new sum here so it is already valid while avg_valid is high
        S_UPDATE: begin
          r_sum           <= w_sum_next;
          r_buf[r_wr_ptr] <= r_sample;
          r_wr_ptr        <= r_wr_ptr + LOG2N'(1);
          r_fill          <= w_fill_next;
          r_full          <= (w_fill_next == (LOG2N+1)'(N));
          r_avg_out       <= w_sum_next[SW-1:LOG2N];
          r_avg_valid     <= 1'b1;
          r_state         <= S_OUTPUT;
        end
        S_OUTPUT: begin
          r_avg_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_CLEAR: begin
          r_buf[r_wr_ptr] <= 10'd0;
          r_wr_ptr        <= r_wr_ptr + LOG2N'(1);
          if (r_wr_ptr == LOG2N'(N - 1)) begin
            r_sum     <= {SW{1'b0}};
            r_fill    <= {(LOG2N+1){1'b0}};
            r_full    <= 1'b0;
            r_avg_out <= 10'd0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_state   <= S_CLEAR;
          end
        end
        default: begin
          r_avg_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign avg_out   = r_avg_out;
  assign avg_valid = r_avg_valid;
  assign full      = r_full;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed bench for adc_moving_avg: ramp-up, ramp-down, full scale, overrun,
// flush and mid-operation reset, each step with hand-computed expectations.
module tb_adc_moving_avg;

  logic       sysclk;
  logic       reset_n;
  logic [9:0] data_in;
  logic       data_valid;
  logic       flush;
  logic [9:0] avg_out;
  logic       avg_valid;
  logic       full;
  logic       busy;
  logic       overrun;

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int p0;

  adc_moving_avg #(.LOG2N(4)) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .flush      (flush),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .full       (full),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (avg_valid === 1'b1) n_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated sample; avg_valid must appear exactly 3 cycles after the edge cycle
  task automatic send(input logic [9:0] val, input int exp_avg, input logic exp_full);
    @(posedge sysclk); #1;
    data_in    = val;
    data_valid = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    check("early_valid", avg_valid, 0);
    @(posedge sysclk); #1;
    check("avg_valid", avg_valid, 1);
    check("avg_out", avg_out, exp_avg);
    check("full", full, exp_full);
    data_valid = 1'b0;
    repeat (6) @(posedge sysclk);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    data_valid = 1'b0;
    flush      = 1'b0;
    data_in    = 10'd0;
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_avg_out", avg_out, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Ramp up with 800
    for (int k = 1; k <= 16; k++) send(10'd800, 50 * k, (k == 16));
    // Ramp down with 0, window stays full
    for (int k = 1; k <= 16; k++) send(10'd0, 50 * (16 - k), 1'b1);
    // Full scale, no wrap
    for (int k = 1; k <= 16; k++) send(10'd1023, (1023 * k) / 16, 1'b1);
    check("pre_overrun", overrun, 0);

    // Second edge two cycles after the first is dropped
    p0 = n_pulses;
    @(posedge sysclk); #1;
    data_in = 10'd0; data_valid = 1'b1;
    @(posedge sysclk); #1;
    data_valid = 1'b0;
    @(posedge sysclk); #1;
    data_in = 10'd500; data_valid = 1'b1;
    @(posedge sysclk); #1;
    check("ovr_valid", avg_valid, 1);
    check("ovr_avg", avg_out, 959);
    check("ovr_flag", overrun, 1);
    data_valid = 1'b0;
    repeat (8) @(posedge sysclk);
    #1;
    check("ovr_pulses", n_pulses - p0, 1);
    check("ovr_busy", busy, 0);

    // Flush after five samples of 400
    do_reset();
    for (int k = 1; k <= 5; k++) send(10'd400, 25 * k, 1'b0);
    p0 = n_pulses;
    @(posedge sysclk); #1;
    flush = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge sysclk); #1;
      check("clr_busy", busy, 1);
      if (k == 3) flush = 1'b0;
      if (k == 5) begin data_in = 10'd999; data_valid = 1'b1; end
      if (k == 7) data_valid = 1'b0;
    end
    @(posedge sysclk); #1;
    check("clr_done_busy", busy, 0);
    check("clr_avg_out", avg_out, 0);
    check("clr_full", full, 0);
    check("clr_overrun", overrun, 1);
    check("clr_pulses", n_pulses - p0, 0);
    send(10'd160, 10, 1'b0);

    // Reset during UPDATE with data_valid held high across release
    @(posedge sysclk); #1;
    data_in = 10'd700; data_valid = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    p0 = n_pulses;
    reset_n = 1'b0;
    #1;
    check("mid_rst_avg_out", avg_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", avg_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    @(posedge sysclk); #5;
    reset_n = 1'b1;
    repeat (8) @(posedge sysclk);
    #1;
    check("rel_busy", busy, 0);
    check("rel_pulses", n_pulses - p0, 0);
    data_valid = 1'b0;
    send(10'd400, 25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_moving_avg.md
ADC_MOVING_AVG -- requirements
Module: adc_moving_avg

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of window length N (N = 16 by default).
REQ-002 SHALL have port sysclk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  10  unsigned sample from the ADC SPI interface.
REQ-005 SHALL have port data_valid  input  1  ADC sample-ready strobe; a sample is taken on its 0->1 transition only.
REQ-006 SHALL have port flush  input  1  synchronous request to zero the window.
REQ-007 SHALL have port avg_out  output  10  registered window average, feeding the DAC, PWM and display path.
REQ-008 SHALL have port avg_valid  output  1  one-cycle pulse marking a new avg_out.
REQ-009 SHALL have port full  output  1  high once N samples have been accepted since reset or flush.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port overrun  output  1  sticky flag; set when a sample edge is dropped.

Function
REQ-012 SHALL register data_valid once (dv_d); edge = data_valid & ~dv_d, evaluated every cycle.
REQ-013 SHALL hold a circular buffer of N 10-bit registers, a LOG2N-bit write pointer wr_ptr, a (10+LOG2N)-bit running sum and a fill counter saturating at N.
REQ-014 SHALL implement FSM states IDLE, READ, UPDATE, OUTPUT, CLEAR.
REQ-015 IDLE: flush -> CLEAR; else edge -> READ, capturing data_in into a sample register; flush has priority over a simultaneous edge, and that edge is dropped.
REQ-016 READ (1 cycle): latch oldest = buf[wr_ptr]; -> UPDATE.
REQ-017 UPDATE (1 cycle): sum <= sum + sample - oldest; buf[wr_ptr] <= sample; wr_ptr <= wr_ptr + 1, wrapping N-1 -> 0; fill increments unless already N; -> OUTPUT.
REQ-018 OUTPUT (1 cycle): avg_out <= sum >> LOG2N (truncating); avg_valid = 1; -> IDLE.
REQ-019 Latency: edge detected in cycle E; avg_valid high in cycle E+3 only; minimum sample spacing is 4 cycles.
REQ-020 Unwritten buffer entries SHALL read as zero, so the average ramps up during the first N samples rather than waiting for fill.
REQ-021 Sum SHALL never overflow: maximum N*1023 fits in 10+LOG2N bits.
REQ-022 full SHALL equal (fill == N), updated in UPDATE.
REQ-023 An edge seen in any state other than IDLE SHALL be dropped and set overrun; overrun clears only on reset.
REQ-024 CLEAR: zero one buffer entry per cycle for N cycles using wr_ptr as index, starting at 0; on completion sum = 0, fill = 0, wr_ptr = 0, avg_out = 0; -> IDLE. No avg_valid is issued; flush held high is ignored during CLEAR.
REQ-025 avg_valid SHALL be low in every state except OUTPUT.

Reset
REQ-026 reset_n low SHALL immediately force: FSM = IDLE, all buffer entries = 0, sum = 0, wr_ptr = 0, fill = 0, dv_d = 0, sample = 0, oldest = 0, avg_out = 0, avg_valid = 0, full = 0, busy = 0, overrun = 0.
REQ-027 Reset asserted mid-operation (any state) SHALL abandon that operation with no partial buffer write and no avg_valid pulse.
REQ-028 After reset_n rises, a data_valid already high SHALL NOT count as an edge until it has been seen low.

Verification
REQ-029 Reset, then 16 edges of data_in = 800 spaced 10 cycles -> avg_out = 50, 100, ..., 800 on successive avg_valid pulses; full rises with the 16th.
REQ-030 From full at 800, 16 samples of 0 -> avg_out steps 750, 700, ..., 0; full stays 1.
REQ-031 16 samples of 1023 -> sum = 16368, avg_out = 1023, no wrap; each avg_valid lands exactly 3 cycles after its edge cycle.
REQ-032 Second data_valid rising edge 2 cycles after the first -> single avg_valid, sum reflects the first sample only, overrun = 1.
REQ-033 flush after 5 samples of 400 -> busy high for 16 cycles, then avg_out = 0 and full = 0; an edge during CLEAR is dropped and overrun = 1; the next sample of 160 gives avg_out = 10.
REQ-034 reset_n pulsed low during UPDATE -> all outputs 0 within the same cycle and no avg_valid follows; with data_valid held high across release, no sample is taken.
